// File: rtl/bt_arb_pkg.sv
// bt_arb_pkg: shared definitions for the Bluetooth UART transmit arbiter.
//   - arb_state_e            : arbiter FSM state encoding (idle / issue / wait)
//   - N_REQ_DEFAULT          : default number of requesters
//   - TIMEOUT_CYCLES_DEFAULT : default tx_done watchdog limit in clk cycles
//   - BYTE_W                 : width of one transmitted byte
package bt_arb_pkg;

    localparam int unsigned N_REQ_DEFAULT          = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 200000;
    localparam int unsigned BYTE_W                 = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Chooses the first set bit of mask at or after ptr+1, wrapping modulo N.
// Ports:
//   mask  in  N   candidate requesters
//   ptr   in  IW  index that was served last
//   grant out IW  chosen index (only meaningful when valid)
//   valid out 1   at least one candidate present
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          valid
);

    always_comb begin
        logic [IW-1:0] cand;
        cand  = '0;
        grant = ptr;
        valid = 1'b0;
        // Scan from the farthest candidate back to the nearest so the nearest wins.
        for (int k = int'(N); k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % int'(N));
            if (mask[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bt_tx_arbiter.sv
// bt_tx_arbiter: shares one byte-at-a-time UART transmitter between N_REQ requesters.
// Each requester queues one byte; grants are round-robin, and a multi-byte frame keeps
// the grant (lock) until its last byte has been sent.
// Optional build macro: BT_ARB_TIMEOUT_EN adds a tx_done watchdog that aborts a stuck
// byte (req_done + req_err) and releases a lock whose owner has gone quiet. Without it
// no counter exists and req_err is tied low.
// Ports:
//   clk, rst   synchronous active-high reset
//   req_start  per-requester byte-valid pulse; req_data byte i at [8i+7:8i]; req_last
//   req_done   per-requester completion pulse; req_err marks an aborted byte
//   tx_start   pulse to the transmitter; tx_data held until tx_done
//   tx_done    transmitter completion pulse
//   busy       high while a byte is being issued or awaited
module bt_tx_arbiter
    import bt_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = N_REQ_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_start,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_done,
    output logic [N_REQ-1:0]        req_err,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_data,
    input  logic                    tx_done,
    output logic                    busy
);

    localparam int unsigned IW = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [N_REQ-1:0]  plast_q, plast_d;
    logic [BYTE_W-1:0] pdata_q [N_REQ];
    logic [BYTE_W-1:0] pdata_d [N_REQ];
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic              cur_last_q, cur_last_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [N_REQ-1:0]  req_done_q, req_done_d;

    logic [N_REQ-1:0]  eligible;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;

`ifdef BT_ARB_TIMEOUT_EN
    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] req_err_q, req_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // While locked only the frame owner may be granted.
    assign eligible = lock_q ? (pend_q & (N_REQ'(1) << owner_q)) : pend_q;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .mask  (eligible),
        .ptr   (rr_ptr_q),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        plast_d    = plast_q;
        pdata_d    = pdata_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        cur_last_d = cur_last_q;
        tx_data_d  = tx_data_q;
        req_done_d = '0;
`ifdef BT_ARB_TIMEOUT_EN
        cnt_d      = '0;
        req_err_d  = '0;
`endif

        // A start while the slot is occupied is dropped; the first byte is kept.
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_start[i] && !pend_q[i]) begin
                pend_d[i]  = 1'b1;
                pdata_d[i] = req_data[BYTE_W*i +: BYTE_W];
                plast_d[i] = req_last[i];
            end
        end

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d          = pick_idx;
                    tx_data_d        = pdata_q[pick_idx];
                    cur_last_d       = plast_q[pick_idx];
                    pend_d[pick_idx] = 1'b0;
                    state_d          = StIssue;
                end
`ifdef BT_ARB_TIMEOUT_EN
                else if (lock_q) begin
                    // Owner went quiet mid-frame: release the others eventually.
                    if (cnt_q == CNT_MAX) begin
                        lock_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    req_done_d[owner_q] = 1'b1;
                    rr_ptr_d            = owner_q;
                    lock_d              = !cur_last_q;
                    state_d             = StIdle;
                end
`ifdef BT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    req_done_d[owner_q] = 1'b1;
                    req_err_d[owner_q]  = 1'b1;
                    rr_ptr_d            = owner_q;
                    lock_d              = 1'b0;
                    state_d             = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pend_q     <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= IW'(N_REQ - 1);
            lock_q     <= 1'b0;
            tx_data_q  <= '0;
            req_done_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            tx_data_q  <= tx_data_d;
            req_done_q <= req_done_d;
        end
    end

    // Payload storage is qualified by pend/state, so it needs no reset.
    always_ff @(posedge clk) begin
        pdata_q    <= pdata_d;
        plast_q    <= plast_d;
        cur_last_q <= cur_last_d;
    end

`ifdef BT_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            req_err_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            req_err_q <= req_err_d;
        end
    end

    assign req_err = req_err_q;
`else
    assign req_err = '0;
`endif

    assign tx_start = (state_q == StIssue);
    assign busy     = (state_q != StIdle);
    assign tx_data  = tx_data_q;
    assign req_done = req_done_q;

endmodule

// File: tb/tb_bt_tx_arbiter.sv
// tb_bt_tx_arbiter: self-checking bench for bt_tx_arbiter (directed scenarios plus a
// randomized run against a cycle-level reference model of the arbitration rules).
module tb_bt_tx_arbiter;

    localparam int unsigned N = 3;
`ifdef BT_ARB_TIMEOUT_EN
    localparam int unsigned TO = 100;
`else
    localparam int unsigned TO = 200000;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_start;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    bt_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_start (req_start),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_done  (req_done),
        .req_err   (req_err),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_start = '0;
        tx_done   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic post(input int i, input logic [7:0] d, input logic l);
        req_start[i]       = 1'b1;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    // Leaves the bench on the cycle where tx_start is high (if seen).
    task automatic wait_tx(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called on the tx_start cycle; returns on the cycle after tx_done.
    task automatic finish_byte(input int gap);
        repeat (gap) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) tick();
        checks++; if (tx_start !== 1'b0) begin failures++;
            $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++;
            $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_done !== '0 || req_err !== '0) begin failures++;
            $display("FAIL reset_done_err got=%b/%b exp=0/0", req_done, req_err); end
    endtask

    task automatic test_single_byte();
        do_reset();
        repeat (5) tick();
        post(0, 8'h41, 1'b1);
        tick();                                   // T+1
        req_start = '0;
        checks++; if (tx_start !== 1'b0) begin failures++;
            $display("FAIL single_early_start got=%b exp=0", tx_start); end
        tick();                                   // T+2
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin failures++;
            $display("FAIL single_issue got=%b/%h exp=1/41", tx_start, tx_data); end
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL single_busy got=%b exp=1", busy); end
        repeat (38) tick();                       // T+40 = D
        tx_done = 1'b1;
        tick();                                   // D+1
        tx_done = 1'b0;
        checks++; if (req_done !== 3'b001 || busy !== 1'b0) begin failures++;
            $display("FAIL single_done got=%b busy=%b exp=001 busy=0", req_done, busy); end
        tick();
        checks++; if (req_done !== 3'b000) begin failures++;
            $display("FAIL single_done_pulse got=%b exp=000", req_done); end
    endtask

    task automatic test_collision();
        bit seen;
        do_reset();
        post(0, 8'h11, 1'b1);
        post(1, 8'h22, 1'b1);
        tick();
        req_start = '0;
        wait_tx(seen);
        checks++; if (!seen || tx_data !== 8'h11) begin failures++;
            $display("FAIL coll_first got=%b/%h exp=1/11", seen, tx_data); end
        finish_byte(3);
        checks++; if (req_done !== 3'b001) begin failures++;
            $display("FAIL coll_done0 got=%b exp=001", req_done); end
        tick();                                   // loser already pending: D+2
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h22) begin failures++;
            $display("FAIL coll_second got=%b/%h exp=1/22", tx_start, tx_data); end
        finish_byte(2);
        checks++; if (req_done !== 3'b010) begin failures++;
            $display("FAIL coll_done1 got=%b exp=010", req_done); end
        // Solo byte from requester 0 leaves the pointer at 0.
        post(0, 8'h00, 1'b1);
        tick();
        req_start = '0;
        wait_tx(seen);
        finish_byte(2);
        post(0, 8'h11, 1'b1);
        post(1, 8'h22, 1'b1);
        tick();
        req_start = '0;
        wait_tx(seen);
        checks++; if (!seen || tx_data !== 8'h22) begin failures++;
            $display("FAIL coll_rr_first got=%b/%h exp=1/22", seen, tx_data); end
        finish_byte(2);
        wait_tx(seen);
        checks++; if (!seen || tx_data !== 8'h11) begin failures++;
            $display("FAIL coll_rr_second got=%b/%h exp=1/11", seen, tx_data); end
        finish_byte(2);
    endtask

    task automatic test_frame_lock();
        bit seen;
        do_reset();
        post(0, 8'hA1, 1'b0);
        tick();
        req_start = '0;
        wait_tx(seen);
        checks++; if (!seen || tx_data !== 8'hA1) begin failures++;
            $display("FAIL frame_b1 got=%b/%h exp=1/a1", seen, tx_data); end
        tick();
        post(1, 8'h99, 1'b1);
        tick();
        req_start = '0;
        finish_byte(3);                           // D+1
        post(0, 8'hA2, 1'b0);
        tick();                                   // D+2: 99 must not sneak in
        req_start = '0;
        checks++; if (tx_start !== 1'b0) begin failures++;
            $display("FAIL frame_lock_hold1 got=%b/%h exp=0", tx_start, tx_data); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA2) begin failures++;
            $display("FAIL frame_b2 got=%b/%h exp=1/a2", tx_start, tx_data); end
        finish_byte(2);
        post(0, 8'hA3, 1'b1);
        tick();
        req_start = '0;
        checks++; if (tx_start !== 1'b0) begin failures++;
            $display("FAIL frame_lock_hold2 got=%b/%h exp=0", tx_start, tx_data); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA3) begin failures++;
            $display("FAIL frame_b3 got=%b/%h exp=1/a3", tx_start, tx_data); end
        finish_byte(2);
        checks++; if (req_done !== 3'b001) begin failures++;
            $display("FAIL frame_done3 got=%b exp=001", req_done); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h99) begin failures++;
            $display("FAIL frame_other got=%b/%h exp=1/99", tx_start, tx_data); end
        finish_byte(2);
        checks++; if (req_done !== 3'b010) begin failures++;
            $display("FAIL frame_other_done got=%b exp=010", req_done); end
    endtask

    task automatic test_duplicate();
        bit seen;
        int extra;
        do_reset();
        post(0, 8'h10, 1'b1);
        tick();
        req_start = '0;
        wait_tx(seen);
        post(1, 8'hAA, 1'b1);
        tick();
        req_start = '0;
        tick();
        post(1, 8'hBB, 1'b1);
        tick();
        req_start = '0;
        finish_byte(2);
        checks++; if (req_done !== 3'b001) begin failures++;
            $display("FAIL dup_done0 got=%b exp=001", req_done); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hAA) begin failures++;
            $display("FAIL dup_first_kept got=%b/%h exp=1/aa", tx_start, tx_data); end
        finish_byte(2);
        checks++; if (req_done !== 3'b010) begin failures++;
            $display("FAIL dup_done1 got=%b exp=010", req_done); end
        extra = 0;
        repeat (20) begin
            tick();
            if (tx_start !== 1'b0 || req_done !== '0) extra++;
        end
        checks++; if (extra != 0) begin failures++;
            $display("FAIL dup_no_second got=%0d exp=0 extra events", extra); end
    endtask

    task automatic test_reset_mid_byte();
        bit seen;
        int extra;
        do_reset();
        post(0, 8'h77, 1'b1);
        tick();
        req_start = '0;
        wait_tx(seen);
        tick();
        post(1, 8'h66, 1'b1);
        tick();
        req_start = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL rstmid_ctrl got=%b/%b exp=0/0", tx_start, busy); end
        checks++; if (tx_data !== 8'h00 || req_done !== '0) begin failures++;
            $display("FAIL rstmid_data got=%h/%b exp=00/000", tx_data, req_done); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++; if (req_done !== '0 || req_err !== '0) begin failures++;
            $display("FAIL rstmid_late_done got=%b/%b exp=000/000", req_done, req_err); end
        extra = 0;
        repeat (10) begin
            tick();
            if (tx_start !== 1'b0 || busy !== 1'b0 || req_done !== '0) extra++;
        end
        checks++; if (extra != 0) begin failures++;
            $display("FAIL rstmid_queue_lost got=%0d exp=0 events", extra); end
    endtask

`ifdef BT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        post(0, 8'h5A, 1'b1);
        post(1, 8'hC3, 1'b1);
        tick();                                   // T+1
        req_start = '0;
        tick();                                   // T+2: issue, WAIT from T+3
        repeat (100) tick();                      // T+102
        checks++; if (req_done !== '0) begin failures++;
            $display("FAIL to_early got=%b exp=000", req_done); end
        tick();                                   // T+103
        checks++; if (req_done !== 3'b001 || req_err !== 3'b001) begin failures++;
            $display("FAIL to_abort got=%b/%b exp=001/001", req_done, req_err); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hC3) begin failures++;
            $display("FAIL to_next got=%b/%h exp=1/c3", tx_start, tx_data); end
        finish_byte(2);
        checks++; if (req_done !== 3'b010 || req_err !== 3'b000) begin failures++;
            $display("FAIL to_next_done got=%b/%b exp=010/000", req_done, req_err); end
    endtask
`endif

    // Reference model: grants follow the rules directly (pending slots, lock, pointer),
    // with expected outputs predicted one cycle ahead.
    task automatic test_random();
        bit             m_pend [N];
        logic [7:0]     m_data [N];
        bit             m_last [N];
        bit             m_inflight, m_lock, m_cur_last, in_wait, td;
        int             m_owner, m_rr, m_issue, m_done_at, grant, idx;
        bit             e_start, e_busy;
        logic [7:0]     e_data;
        logic [N-1:0]   e_done, s, l;
        logic [8*N-1:0] d;

        do_reset();
        m_inflight = 0; m_lock = 0; m_cur_last = 0;
        m_owner = 0; m_rr = N - 1; m_issue = 0; m_done_at = 0;
        e_start = 0; e_busy = 0; e_data = 8'h00; e_done = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_data[i] = 8'h00; m_last[i] = 0;
        end

        for (int c = 0; c < 3000; c++) begin
            checks++; if (tx_start !== e_start) begin failures++;
                $display("FAIL rnd_tx_start cyc=%0d got=%b exp=%b", c, tx_start, e_start); end
            if (e_start) begin
                checks++; if (tx_data !== e_data) begin failures++;
                    $display("FAIL rnd_tx_data cyc=%0d got=%h exp=%h", c, tx_data, e_data); end
            end
            checks++; if (busy !== e_busy) begin failures++;
                $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, e_busy); end
            checks++; if (req_done !== e_done || req_err !== '0) begin failures++;
                $display("FAIL rnd_done cyc=%0d got=%b/%b exp=%b/000",
                         c, req_done, req_err, e_done); end

            for (int i = 0; i < N; i++) begin
                s[i]        = ($urandom_range(0, 4) == 0);
                l[i]        = 1'($urandom_range(0, 1));
                d[8*i +: 8] = 8'($urandom);
            end
            in_wait = m_inflight && (c > m_issue);
            td      = in_wait ? (c == m_done_at) : ($urandom_range(0, 15) == 0);
            req_start = s;
            req_last  = l;
            req_data  = d;
            tx_done   = td;

            e_start = 0;
            e_done  = '0;
            grant   = -1;
            if (!m_inflight) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_rr + k) % N;
                    if (grant < 0 && m_pend[idx] && (!m_lock || idx == m_owner)) grant = idx;
                end
            end else if (in_wait && td) begin
                e_done[m_owner] = 1'b1;
                m_rr            = m_owner;
                m_lock          = !m_cur_last;
                m_inflight      = 0;
            end
            if (grant >= 0) begin
                m_owner    = grant;
                e_start    = 1;
                e_data     = m_data[grant];
                m_cur_last = m_last[grant];
                m_inflight = 1;
                m_issue    = c + 1;
                m_done_at  = c + 1 + int'($urandom_range(1, 15));
            end
            for (int i = 0; i < N; i++) begin
                if (s[i] && !m_pend[i]) begin
                    m_pend[i] = 1;
                    m_data[i] = d[8*i +: 8];
                    m_last[i] = l[i];
                end
            end
            if (grant >= 0) m_pend[grant] = 0;
            e_busy = m_inflight;
            tick();
        end
        req_start = '0;
        tx_done   = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_start = '0;
        req_data  = '0;
        req_last  = '0;
        tx_done   = 1'b0;
        test_reset();
        test_single_byte();
        test_collision();
        test_frame_lock();
        test_duplicate();
        test_reset_mid_byte();
`ifdef BT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
